cbadc_modulator_fxp: RTL

Cycle-accurate fixed-point model of the control-bounded ADC front end, the encoder that produces the M-bit control-decision stream consumed by the batch fixed-point estimator. Each enabled clock it advances a chain of N integrators driven by a signed input sample and emits one control bit per integrator. It is used as a synthesizable stimulus source in loopback benches and as an on-chip test-pattern generator ahead of the estimator's `in` port.

---
 rtl/cbadc_modulator_fxp.sv | 101 ++++++++++
 1 files changed

// File: rtl/cbadc_modulator_fxp.sv
// Control-bounded ADC encoder: N saturating integrators with bang-bang feedback.
// Each enabled clock advances every stage at once and registers one control bit per stage.
module cbadc_modulator_fxp #(
    parameter int          N          = 4,
    parameter int          n_int      = 2,
    parameter int          n_mant     = 8,
    parameter int          BETA_SHIFT = 0,
    parameter int unsigned KAPPA_RAW  = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         in_valid,
    input  logic signed [n_int+n_mant:0] u,
    output logic        [N-1:0]          out,
    output logic                         out_valid,
    output logic                         ovf
);
    localparam int NTOT = n_int + n_mant;
    localparam int SW   = NTOT + 1;
    localparam int EW   = NTOT + 3;

    localparam logic signed [EW-1:0] MAXV  = EW'(2 ** NTOT - 1);
    localparam logic signed [EW-1:0] MINV  = ~MAXV;
    localparam logic signed [EW-1:0] KAPPA = EW'(KAPPA_RAW);

    function automatic logic signed [SW-1:0] sat(input logic signed [EW-1:0] s);
        if (s > MAXV) begin
            return MAXV[SW-1:0];
        end else if (s < MINV) begin
            return MINV[SW-1:0];
        end else begin
            return s[SW-1:0];
        end
    endfunction

    function automatic logic clipped(input logic signed [EW-1:0] s);
        return (s > MAXV) || (s < MINV);
    endfunction

    logic signed [SW-1:0] r_x [N];
    logic        [N-1:0]  r_out;
    logic                 r_out_valid;
    logic                 r_ovf;

    logic        [N-1:0]  w_d;
    logic        [N-1:0]  w_clip;
    logic signed [SW-1:0] w_v    [N];
    logic signed [EW-1:0] w_sum  [N];
    logic signed [SW-1:0] w_next [N];

    // Stage inputs read the pre-update state of the previous stage, so all stages step together.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign w_v[gi] = u >>> BETA_SHIFT;
            end else begin : g_tail
                assign w_v[gi] = r_x[gi-1] >>> BETA_SHIFT;
            end
            assign w_d[gi]    = ~r_x[gi][SW-1];
            assign w_sum[gi]  = EW'(r_x[gi]) + EW'(w_v[gi]) + (w_d[gi] ? -KAPPA : KAPPA);
            assign w_next[gi] = sat(w_sum[gi]);
            assign w_clip[gi] = clipped(w_sum[gi]);
        end
    endgenerate

    // Register stage: state, decisions and sticky overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < N; k++) begin
                r_x[k] <= '0;
            end
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (clr) begin
            for (int k = 0; k < N; k++) begin
                r_x[k] <= '0;
            end
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (in_valid) begin
            for (int k = 0; k < N; k++) begin
                r_x[k] <= w_next[k];
            end
            r_out       <= w_d;
            r_out_valid <= 1'b1;
            if (|w_clip) begin
                r_ovf <= 1'b1;
            end
        end else begin
            r_out_valid <= 1'b0;
        end
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign ovf       = r_ovf;
endmodule
